// File: rtl/alu_shift_pkg.sv
// Shared types and constants for the iterative ALU shift units.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package alu_shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shift_state_t;

    localparam int SHIFT_STAGES = 5;
    localparam int SHIFT_AMT_W  = 32;

endpackage

// File: rtl/shift_stage_l.sv
// Conditional logical left shift by 2^stage, zero filled from bit 0.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module shift_stage_l
    import alu_shift_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = SHIFT_STAGES,
    parameter int SW     = $clog2(STAGES + 1)
) (
    input  logic             en,
    input  logic [SW-1:0]    stage,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    always_comb begin
        dout = din;
        if (en) begin
            dout = din << (WIDTH'(1) << stage);
        end
    end

endmodule

// File: rtl/sll_iter.sv
// Iterative logical left shifter, one power-of-two stage per clock; SLL_SAT_EN zeroes out-of-range shifts.
// Latency: STAGES cycles from accept to out_valid (5 at WIDTH=32), fixed for any shift amount.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module sll_iter
    import alu_shift_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       a,
    input  logic [SHIFT_AMT_W-1:0] movement,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out,
    output logic                   busy
);

    localparam int STAGES = $clog2(WIDTH);
    localparam int SW     = $clog2(STAGES + 1);
    localparam logic [SW-1:0] LAST = SW'(STAGES - 1);

    shift_state_t      state_q, state_d;
    logic [WIDTH-1:0]  data_q, out_q, stage_dat;
    logic [STAGES-1:0] amt_q;
    logic [SW-1:0]     stage_q;
    logic              accept, over_range;

    assign accept = (state_q == IDLE) && in_valid;

`ifdef SLL_SAT_EN
    assign over_range = |movement[SHIFT_AMT_W-1:STAGES];
`else
    // Upper amount bits are don't-care: shift is modulo WIDTH like the right-shift unit.
    logic unused_amt_hi;
    assign unused_amt_hi = |movement[SHIFT_AMT_W-1:STAGES];
    assign over_range    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = SHIFT;
            SHIFT:   if (stage_q == LAST) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    shift_stage_l #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES),
        .SW     (SW)
    ) u_stage (
        .en    (amt_q[stage_q]),
        .stage (stage_q),
        .din   (data_q),
        .dout  (stage_dat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            amt_q   <= '0;
            stage_q <= '0;
            out_q   <= '0;
        end else if (accept) begin
            // Out-of-range amounts zero the operand up front so every stage still runs.
            data_q  <= over_range ? '0 : a;
            amt_q   <= movement[STAGES-1:0];
            stage_q <= '0;
        end else if (state_q == SHIFT) begin
            data_q  <= stage_dat;
            stage_q <= stage_q + SW'(1);
            if (stage_q == LAST) begin
                out_q <= stage_dat;
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out       = out_q;

endmodule

// File: tb/tb_sll_iter.sv
// Directed and random checks of sll_iter against a shift reference model via an in-order scoreboard.
module tb_sll_iter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] movement;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        busy;

    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_miss   = 0;
    int          n_sent   = 0;
    int          n_recv   = 0;
    int          lat;
    bit          done     = 1'b0;

    sll_iter #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .movement  (movement),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_sll(input logic [31:0] av, input logic [31:0] mv);
`ifdef SLL_SAT_EN
        if (mv[31:5] != 27'd0) return 32'd0;
`endif
        return av << mv[4:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] av, input logic [31:0] mv, input bit push);
        int w = 0;
        while (!in_ready && w < 100) begin
            tick();
            w++;
        end
        check("accept_wait", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        a        = av;
        movement = mv;
        if (push) begin
            exp_q.push_back(ref_sll(av, mv));
            n_sent++;
        end
        tick();
        in_valid = 1'b0;
        a        = $urandom;
        movement = $urandom;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            tick();
            cyc++;
        end
    endtask

    // Handshake happens at the next posedge; sample mid-cycle.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_recv++;
            check("sb_nonempty", {31'd0, (exp_q.size() != 0)}, 32'd1);
            if (exp_q.size() != 0) begin
                check("sb_out", out, exp_q.pop_front());
            end
        end
    end

    initial begin
        in_valid  = 1'b0;
        a         = '0;
        movement  = '0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        #2;
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_out",       out,                32'd0);
        #20 rst_n = 1'b1;
        tick();

        out_ready = 1'b1;
        send(32'h0000_0001, 32'd5, 1'b1);
        wait_valid(lat);
        check("lat_shl5", lat, 32'd5);
        check("out_shl5", out, 32'h0000_0020);

        send(32'h8000_0001, 32'd31, 1'b1);
        wait_valid(lat);
        check("lat_shl31", lat, 32'd5);
        check("out_shl31", out, 32'h8000_0000);

        send(32'hDEAD_BEEF, 32'd0, 1'b1);
        wait_valid(lat);
        check("lat_shl0", lat, 32'd5);
        check("out_shl0", out, 32'hDEAD_BEEF);

        send(32'hDEAD_BEEF, 32'h24, 1'b1);
        wait_valid(lat);
        check("lat_shl24h", lat, 32'd5);

        // Stalled consumer with a competing request during DONE
        send(32'h1234_5678, 32'd4, 1'b1);
        out_ready = 1'b0;
        wait_valid(lat);
        check("lat_stall", lat, 32'd5);
        in_valid = 1'b1;
        a        = 32'hFFFF_FFFF;
        movement = 32'd1;
        repeat (3) begin
            tick();
            check("stall_out",       out,                32'h2345_6780);
            check("stall_in_ready",  {31'd0, in_ready},  32'd0);
            check("stall_out_valid", {31'd0, out_valid}, 32'd1);
        end
        exp_q.push_back(ref_sll(32'hFFFF_FFFF, 32'd1));
        n_sent++;
        out_ready = 1'b1;
        tick();
        check("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
        check("post_hs_busy",     {31'd0, busy},     32'd0);
        check("post_hs_out_held", out,               32'h2345_6780);
        tick();
        in_valid = 1'b0;
        check("late_accept_busy", {31'd0, busy}, 32'd1);
        wait_valid(lat);
        check("lat_late_accept", lat, 32'd5);

        // Reset in the middle of a shift
        send(32'hFFFF_FFFF, 32'd3, 1'b0);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_out",       out,                32'd0);
        check("abort_busy",      {31'd0, busy},      32'd0);
        check("abort_in_ready",  {31'd0, in_ready},  32'd1);
        #10 rst_n = 1'b1;
        check("release_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("release_busy", {31'd0, busy}, 32'd0);
        check("release_sb_empty", exp_q.size(), 32'd0);

        // Back-to-back random operands with random consumer stalls
        fork
            begin
                int w;
                for (int i = 0; i < 20; i++) begin
                    logic [31:0] av, mv;
                    av = $urandom;
                    mv = $urandom_range(0, 31);
                    if (i % 6 == 5) mv[8] = 1'b1;
                    send(av, mv, 1'b1);
                end
                w = 0;
                while (exp_q.size() != 0 && w < 1000) begin
                    tick();
                    w++;
                end
                check("drain", exp_q.size(), 32'd0);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    tick();
                end
                out_ready = 1'b1;
            end
        join

        check("recv_count", n_recv, n_sent);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miss);
        $finish;
    end

endmodule
